// File: rtl/img_pixel_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : img_pixel_sequencer
// Description : Issues one-at-a-time pixel requests, buffers returned pixels
//               in a small FIFO and exposes them through an Avalon-MM slave.
//               Optional WAIT watchdog enabled by IMG_SEQ_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module img_pixel_sequencer #(
  parameter int FIFO_DEPTH    = 8,
  parameter int PIX_PER_FRAME = 307200,
  parameter int CNT_W         = 20,
  parameter int TIMEOUT_CYC   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  output logic        get_next_pix,
  input  logic        pix_rdy,
  input  logic [23:0] pixel_data,
  input  logic        img_done,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic [3:0]  out_state
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_LVL_W = c_PTR_W + 1;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_REQ  = 4'd1,
    S_WAIT = 4'd2,
    S_DONE = 4'd3,
    S_ERR  = 4'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [23:0]          r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_LVL_W-1:0]   r_level;
  logic [CNT_W-1:0]     r_count;
  logic                 r_done;
  logic                 r_err;
  logic [31:0]          r_readdata;

  logic w_ctrl_wr, w_start, w_abort;
  logic w_empty, w_full, w_pop;
  logic w_req, w_push, w_flush, w_clear, w_set_done, w_set_err;
  logic w_timeout;
  logic w_unused;

  assign w_ctrl_wr = avs_write && (avs_address == 2'd0);
  assign w_start   = w_ctrl_wr && avs_writedata[0];
  assign w_abort   = w_ctrl_wr && avs_writedata[1];
  assign w_empty   = (r_level == '0);
  assign w_full    = (r_level == c_LVL_W'(FIFO_DEPTH));
  assign w_pop     = avs_read && (avs_address == 2'd2) && !w_empty;

`ifdef IMG_SEQ_TIMEOUT_EN
  localparam int c_TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [c_TO_W-1:0] r_wait_cnt;

  // Cleared on the request pulse, so it counts WAIT cycles from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_cnt <= '0;
    end else if (w_req) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_wait_cnt <= r_wait_cnt + c_TO_W'(1);
    end
  end

  assign w_timeout = (r_state == S_WAIT) && (r_wait_cnt == c_TO_W'(TIMEOUT_CYC - 1));
  assign w_unused  = ^avs_writedata[31:2];
`else
  assign w_timeout = 1'b0;
  assign w_unused  = ^{avs_writedata[31:2], (TIMEOUT_CYC > 0)};
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_push      = 1'b0;
    w_flush     = 1'b0;
    w_clear     = 1'b0;
    w_set_done  = 1'b0;
    w_set_err   = 1'b0;
    if (w_abort) begin
      w_state_nxt = S_IDLE;
      w_flush     = 1'b1;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (w_start) begin
            w_state_nxt = S_REQ;
            w_flush     = 1'b1;
            w_clear     = 1'b1;
          end
        end
        S_REQ: begin
          if (!w_full) begin
            w_req       = 1'b1;
            w_state_nxt = S_WAIT;
          end
        end
        S_WAIT: begin
          if (pix_rdy) begin
            w_push = 1'b1;
            if ((r_count == CNT_W'(PIX_PER_FRAME - 1)) || img_done) begin
              w_state_nxt = S_DONE;
              w_set_done  = 1'b1;
            end else begin
              w_state_nxt = S_REQ;
            end
          end else if (img_done) begin
            w_state_nxt = S_DONE;
            w_set_done  = 1'b1;
          end else if (w_timeout) begin
            w_state_nxt = S_ERR;
            w_set_err   = 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clear) begin
        r_count <= '0;
        r_done  <= 1'b0;
        r_err   <= 1'b0;
      end else begin
        if (w_push)     r_count <= r_count + CNT_W'(1);
        if (w_set_done) r_done  <= 1'b1;
        if (w_set_err)  r_err   <= 1'b1;
      end
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
        if (w_push && !w_pop)      r_level <= r_level + c_LVL_W'(1);
        else if (!w_push && w_pop) r_level <= r_level - c_LVL_W'(1);
      end
    end
  end

  // Storage needs no reset; only pointers and level define its contents.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= pixel_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_readdata <= '0;
    end else if (avs_read) begin
      case (avs_address)
        2'd1:    r_readdata <= {12'd0, w_full, w_empty, r_err, r_done, 4'd0,
                                4'(r_level), 4'd0, r_state};
        2'd2:    r_readdata <= w_pop ? {1'b1, 7'd0, r_mem[r_rd_ptr]} : 32'd0;
        2'd3:    r_readdata <= 32'(r_count);
        default: r_readdata <= 32'd0;
      endcase
    end
  end

  assign get_next_pix = w_req;
  assign avs_readdata = r_readdata;
  assign out_state    = r_state;

endmodule
`default_nettype wire
